apb4_csr_master: RTL and testbench

APB4 initiator that turns single-beat command requests on a valid/ready channel into APB4 transfers and returns each completion on a valid/ready response channel. It runs in the PCLK domain and drives the CSR-side APB bus. Configuration and status software sequencers use it to program and poll APB slaves, including draining sample registers. One transfer is outstanding at a time. Wait states and PSLVERR are fully honoured.

---
 rtl/apb4_csr_master.sv | 151 +++++++++++++++
 tb/tb_apb4_csr_master.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_csr_master.sv
// APB4 initiator: one outstanding transfer, valid/ready command in, valid/ready response out.
// Define APB4_CSR_MASTER_TIMEOUT_EN to add a PREADY watchdog that terminates stalled transfers.
module apb4_csr_master #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int TO_MAX = 255
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [DW-1:0]   cmd_wdata,
    input  logic [DW/8-1:0] cmd_wstrb,
    input  logic [2:0]      cmd_prot,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic            rsp_timeout,
    output logic            PSEL,
    output logic            PENABLE,
    output logic [AW-1:0]   PADDR,
    output logic            PWRITE,
    output logic [DW-1:0]   PWDATA,
    output logic [DW/8-1:0] PSTRB,
    output logic [2:0]      PPROT,
    input  logic [DW-1:0]   PRDATA,
    input  logic            PREADY,
    input  logic            PSLVERR
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]      r_state;
    logic [AW-1:0]   r_paddr;
    logic            r_pwrite;
    logic [DW-1:0]   r_pwdata;
    logic [DW/8-1:0] r_pstrb;
    logic [2:0]      r_pprot;
    logic [DW-1:0]   r_rdata;
    logic            r_err;
    logic            w_timeout;

`ifdef APB4_CSR_MASTER_TIMEOUT_EN
    localparam int CW = ($clog2(TO_MAX + 1) > 8) ? $clog2(TO_MAX + 1) : 8;
    localparam logic [CW-1:0] TO_LIM = CW'(TO_MAX);

    logic [CW-1:0] r_toCnt;
    logic          r_timeout;

    // Counts PREADY-low ACCESS cycles; saturates at the limit, which ends the transfer anyway.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_toCnt <= '0;
        end else if (r_state == SETUP) begin
            r_toCnt <= '0;
        end else if (r_state == ACCESS && !PREADY && r_toCnt != TO_LIM) begin
            r_toCnt <= r_toCnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == ACCESS) && !PREADY && (r_toCnt == TO_LIM);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_timeout <= 1'b0;
        end else if (r_state == ACCESS) begin
            if (PREADY) begin
                r_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign rsp_timeout = r_timeout;
`else
    logic w_unusedToMax;

    assign w_unusedToMax = (TO_MAX != 0);
    assign w_timeout     = 1'b0;
    assign rsp_timeout   = 1'b0;
`endif

    // PREADY takes priority over the watchdog when both occur in the same cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state  <= IDLE;
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
            r_pprot  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_paddr  <= cmd_addr;
                        r_pwrite <= cmd_write;
                        r_pwdata <= cmd_wdata;
                        r_pstrb  <= cmd_write ? cmd_wstrb : '0;
                        r_pprot  <= cmd_prot;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        r_rdata <= r_pwrite ? '0 : PRDATA;
                        r_err   <= PSLVERR;
                        r_state <= RESP;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign PSEL      = (r_state == SETUP) || (r_state == ACCESS);
    assign PENABLE   = (r_state == ACCESS);
    assign rsp_valid = (r_state == RESP);
    assign PADDR     = r_paddr;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;
    assign PSTRB     = r_pstrb;
    assign PPROT     = r_pprot;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_apb4_csr_master.sv
// Directed self-checking bench for apb4_csr_master; the slave side is driven straight from the stimulus.
// With APB4_CSR_MASTER_TIMEOUT_EN defined the watchdog path is checked, otherwise the indefinite wait.
module tb_apb4_csr_master;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int vecCount = 0;
    int errCount = 0;

    apb4_csr_master #(.AW(32), .DW(32), .TO_MAX(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Hard stop in case some wait below is mis-bounded.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running expected finished");
        $fatal(1, "[TB] global time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Presents a command and returns at the falling edge just after it was accepted (SETUP cycle).
    task automatic applyStimulus(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input logic [2:0] prot);
        int n;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = strb;
        cmd_prot  = prot;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        checkOutput("cmdAccept", {63'd0, cmd_ready}, 64'd1);
        @(negedge PCLK);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n;
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        cmd_prot  = '0;
        rsp_ready = 1'b1;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        // Reset state
        @(negedge PCLK);
        @(negedge PCLK);
        checkOutput("rstCmdReady", {63'd0, cmd_ready}, 64'd1);
        checkOutput("rstBus", {60'd0, PSEL, PENABLE, rsp_valid, rsp_err}, 64'd0);
        checkOutput("rstPaddr", {32'd0, PADDR}, 64'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Write, zero-wait slave
        PREADY = 1'b1;
        applyStimulus(1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 3'b010);
        checkOutput("wrSetupSelEn", {62'd0, PSEL, PENABLE}, 64'b10);
        checkOutput("wrSetupCmdReady", {63'd0, cmd_ready}, 64'd0);
        checkOutput("wrSetupCtl", {25'd0, PWRITE, PSTRB, PPROT, PADDR}, {25'd0, 1'b1, 4'hF, 3'b010, 32'h10});
        checkOutput("wrSetupData", {32'd0, PWDATA}, {32'd0, 32'hA5A5_0001});
        @(negedge PCLK);
        checkOutput("wrAccessSelEn", {62'd0, PSEL, PENABLE}, 64'b11);
        checkOutput("wrAccessRspValid", {63'd0, rsp_valid}, 64'd0);
        @(negedge PCLK);
        checkOutput("wrRespSelEn", {62'd0, PSEL, PENABLE}, 64'b00);
        checkOutput("wrRespFlags", {61'd0, rsp_valid, rsp_err, rsp_timeout}, 64'b100);
        checkOutput("wrRespRdata", {32'd0, rsp_rdata}, 64'd0);
        @(negedge PCLK);
        checkOutput("wrIdle", {62'd0, rsp_valid, cmd_ready}, 64'b01);

        // Read with 3 wait states
        PREADY = 1'b0;
        PRDATA = 32'hFFFF_0000;
        applyStimulus(1'b0, 32'h08, 32'h5555_5555, 4'hF, 3'b001);
        checkOutput("rdSetup", {58'd0, PSEL, PENABLE, PSTRB}, {58'd0, 2'b10, 4'h0});
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            checkOutput("rdWait", {25'd0, PSEL, PENABLE, PWRITE, PSTRB, PADDR, rsp_valid},
                        {25'd0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h08, 1'b0});
        end
        @(negedge PCLK);
        checkOutput("rdLastAccess", {62'd0, PSEL, PENABLE}, 64'b11);
        PREADY = 1'b1;
        PRDATA = 32'h1234_5678;
        @(negedge PCLK);
        PREADY = 1'b0;
        PRDATA = 32'h0BAD_0BAD;
        checkOutput("rdResp", {29'd0, PSEL, rsp_valid, rsp_err, rsp_rdata}, {29'd0, 1'b0, 1'b1, 1'b0, 32'h1234_5678});
        @(negedge PCLK);

        // Slave error on read
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        applyStimulus(1'b0, 32'hFC, 32'h0, 4'hF, 3'b000);
        @(negedge PCLK);
        @(negedge PCLK);
        PSLVERR = 1'b0;
        checkOutput("errResp", {61'd0, rsp_valid, rsp_err, rsp_timeout}, 64'b110);
        @(negedge PCLK);

        // Response backpressure with a second command waiting
        rsp_ready = 1'b0;
        PREADY    = 1'b1;
        PRDATA    = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 32'h24, 32'h0, 4'hF, 3'b000);
        @(negedge PCLK);
        @(negedge PCLK);
        PRDATA    = 32'h0000_1111;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h44;
        cmd_wdata = 32'hCAFE_0002;
        cmd_wstrb = 4'h3;
        cmd_prot  = 3'b100;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bpHold", {29'd0, rsp_valid, cmd_ready, PSEL, rsp_rdata},
                        {29'd0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF});
            @(negedge PCLK);
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        checkOutput("bpAfterHs", {62'd0, rsp_valid, cmd_ready}, 64'b01);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        checkOutput("bpSecondSetup", {26'd0, PSEL, PENABLE, PSTRB, PADDR}, {26'd0, 2'b10, 4'h3, 32'h44});
        @(negedge PCLK);
        @(negedge PCLK);
        checkOutput("bpSecondResp", {62'd0, rsp_valid, rsp_err}, 64'b10);
        @(negedge PCLK);

        // Stalled slave
        PREADY = 1'b0;
        PRDATA = 32'h7777_7777;
        applyStimulus(1'b0, 32'h30, 32'h0, 4'hF, 3'b000);
        @(negedge PCLK);
        n = 0;
        while (PSEL && n < 40) begin
            n++;
            @(negedge PCLK);
        end
`ifdef APB4_CSR_MASTER_TIMEOUT_EN
        checkOutput("toAccessCycles", n, 64'd5);
        checkOutput("toResp", {61'd0, rsp_valid, rsp_err, rsp_timeout}, 64'b111);
        checkOutput("toRdata", {32'd0, rsp_rdata}, 64'd0);
        @(negedge PCLK);
        checkOutput("toIdle", {63'd0, cmd_ready}, 64'd1);
`else
        checkOutput("stallCycles", n, 64'd40);
        checkOutput("stallBus", {61'd0, PSEL, PENABLE, rsp_valid}, 64'b110);
        PRESETn = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
`endif

        // Reset asserted during wait states
        PREADY = 1'b0;
        applyStimulus(1'b0, 32'h40, 32'h0, 4'hF, 3'b000);
        @(negedge PCLK);
        @(negedge PCLK);
        checkOutput("rstMidPre", {62'd0, PSEL, PENABLE}, 64'b11);
        PRESETn = 1'b0;
        #1;
        checkOutput("rstMidBus", {61'd0, PSEL, PENABLE, rsp_valid}, 64'b000);
        checkOutput("rstMidPaddr", {32'd0, PADDR}, 64'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        PREADY  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            checkOutput("rstNoStale", {61'd0, rsp_valid, PSEL, cmd_ready}, 64'b001);
        end

        // Recovery transfer after reset
        applyStimulus(1'b1, 32'h50, 32'h0000_00AB, 4'h1, 3'b000);
        @(negedge PCLK);
        @(negedge PCLK);
        checkOutput("recResp", {61'd0, rsp_valid, rsp_err, rsp_timeout}, 64'b100);
        @(negedge PCLK);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
